// File: rtl/oscope_pkg.sv
// Shared constants for the oscilloscope data path: packet geometry, ASCII codes,
// FIFO FSM state encodings and the packetizer state type.
package oscope_pkg;

    localparam int PKT_LEN = 13;

    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    localparam logic [1:0] FIFO_S0 = 2'd0;
    localparam logic [1:0] FIFO_S1 = 2'd1;
    localparam logic [1:0] FIFO_S2 = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        READY,
        HANDOFF
    } pkt_state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10)
            return ASCII_0 + {4'd0, nibble};
        else
            return ASCII_A + {4'd0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift-add-3 step per cycle, done pulses on the
// cycle after the last step while bcd holds the final result.
module bin2bcd_seq #(
    parameter int CONV_CYCLES = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [CONV_CYCLES-1:0] bin,
    output logic                   done,
    output logic [15:0]            bcd
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);

    logic [CONV_CYCLES-1:0] shift_reg;
    logic [CNT_W-1:0]       count;
    logic [15:0]            adjusted;

    // Add 3 to every digit of 5 or more so the following shift carries correctly
    always_comb begin
        adjusted = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bcd       <= '0;
            count     <= '0;
            done      <= 1'b0;
        end else if (start) begin
            shift_reg <= bin;
            bcd       <= '0;
            count     <= CNT_W'(CONV_CYCLES);
            done      <= 1'b0;
        end else if (count != '0) begin
            bcd       <= {adjusted[14:0], shift_reg[CONV_CYCLES-1]};
            shift_reg <= {shift_reg[CONV_CYCLES-2:0], 1'b0};
            count     <= count - CNT_W'(1);
            done      <= (count == CNT_W'(1));
        end else begin
            done      <= 1'b0;
        end
    end

endmodule

// File: rtl/sample_packetizer.sv
// Converts one ADC sample per strobe into a 13-character ASCII packet and hands it
// to the FT232H FIFO-write FSM, double-buffered so a packet in flight is never touched.
module sample_packetizer
    import oscope_pkg::*;
#(
    parameter int SEQ_W       = 16,
    parameter int CONV_CYCLES = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_valid,
    input  logic [CONV_CYCLES-1:0] sample,
    input  logic [2:0]             channel,
    input  logic [1:0]             fsm_state,
    input  logic [3:0]             select,
    output logic [7:0]             data_out,
    output logic                   enable,
    output logic                   busy,
    output logic                   overrun
);

    pkt_state_t       state;
    logic [2:0]       work_channel;
    logic [SEQ_W-1:0] seq;
    logic [2:0]       out_channel;
    logic [15:0]      out_bcd;
    logic [SEQ_W-1:0] out_seq;
    logic             conv_start;
    logic             conv_done;
    logic [15:0]      conv_bcd;

    assign conv_start = (state == IDLE) && sample_valid;

    bin2bcd_seq #(
        .CONV_CYCLES(CONV_CYCLES)
    ) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (sample),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    // Output registers only load on READY -> HANDOFF, i.e. while downstream is idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            enable       <= 1'b1;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            work_channel <= '0;
            seq          <= '0;
            out_channel  <= '0;
            out_bcd      <= '0;
            out_seq      <= '0;
        end else begin
            overrun <= sample_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        work_channel <= channel;
                        busy         <= 1'b1;
                        state        <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (conv_done)
                        state <= READY;
                end
                READY: begin
                    if (fsm_state == FIFO_S2) begin
                        out_channel <= work_channel;
                        out_bcd     <= conv_bcd;
                        out_seq     <= seq;
                        seq         <= seq + SEQ_W'(1);
                        enable      <= 1'b0;
                        state       <= HANDOFF;
                    end
                end
                HANDOFF: begin
                    if (fsm_state != FIFO_S2) begin
                        enable <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (select)
            4'd0:  data_out = ASCII_C;
            4'd1:  data_out = ASCII_0 + {5'd0, out_channel};
            4'd2:  data_out = ASCII_COLON;
            4'd3:  data_out = ASCII_0 + {4'd0, out_bcd[15:12]};
            4'd4:  data_out = ASCII_0 + {4'd0, out_bcd[11:8]};
            4'd5:  data_out = ASCII_0 + {4'd0, out_bcd[7:4]};
            4'd6:  data_out = ASCII_0 + {4'd0, out_bcd[3:0]};
            4'd7:  data_out = ASCII_COMMA;
            4'd8:  data_out = hex_ascii(out_seq[15:12]);
            4'd9:  data_out = hex_ascii(out_seq[11:8]);
            4'd10: data_out = hex_ascii(out_seq[7:4]);
            4'd11: data_out = hex_ascii(out_seq[3:0]);
            4'd12: data_out = ASCII_LF;
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_sample_packetizer.sv
// Scoreboard bench: stimulus queues the packet each accepted sample should produce,
// a monitor reads back the packet whenever enable falls and compares.
module tb_sample_packetizer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic [2:0]  channel = '0;
    logic [1:0]  fsm_state = 2'd0;
    logic [3:0]  select = '0;
    logic [7:0]  data_out;
    logic        enable;
    logic        busy;
    logic        overrun;

    int passCnt = 0;
    int checkCnt = 0;
    logic [103:0] expQ[$];

    sample_packetizer #(
        .SEQ_W(16),
        .CONV_CYCLES(12)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .channel      (channel),
        .fsm_state    (fsm_state),
        .select       (select),
        .data_out     (data_out),
        .enable       (enable),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #20 clk = ~clk;

    // Character i lives at bits [8*i +: 8]; decimal and hex digits computed arithmetically
    function automatic logic [103:0] makePacket(input int ch, input int smp, input int sq);
        logic [103:0] p;
        int nib;
        p = '0;
        p[0 +: 8]  = 8'h43;
        p[8 +: 8]  = 8'(8'h30 + ch);
        p[16 +: 8] = 8'h3A;
        p[24 +: 8] = 8'(8'h30 + (smp / 1000) % 10);
        p[32 +: 8] = 8'(8'h30 + (smp / 100) % 10);
        p[40 +: 8] = 8'(8'h30 + (smp / 10) % 10);
        p[48 +: 8] = 8'(8'h30 + smp % 10);
        p[56 +: 8] = 8'h2C;
        for (int k = 0; k < 4; k++) begin
            nib = (sq >> (12 - 4 * k)) & 15;
            p[64 + 8 * k +: 8] = (nib < 10) ? 8'(8'h30 + nib) : 8'(8'h41 + nib - 10);
        end
        p[96 +: 8] = 8'h0A;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [103:0] actual, input logic [103:0] expected);
        checkCnt++;
        if (actual === expected)
            passCnt++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readPacket(output logic [103:0] p);
        p = '0;
        for (int i = 0; i < 13; i++) begin
            select = 4'(i);
            #1;
            p[8 * i +: 8] = data_out;
        end
    endtask

    task automatic applyStimulus(input int smp, input int ch);
        sample       = 12'(smp);
        channel      = 3'(ch);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic waitEnable(input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (enable !== val && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, {103'd0, enable}, {103'd0, val});
    endtask

    // Monitor: a falling enable means a fresh packet is presented downstream
    initial begin
        logic [103:0] got;
        logic [103:0] exp;
        logic prevEn;
        prevEn = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prevEn = 1'b1;
            end else begin
                if (prevEn && !enable) begin
                    readPacket(got);
                    if (expQ.size() == 0) begin
                        checkCnt++;
                        $display("[TB] FAIL unexpected_packet: got %h, expected none", got);
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput("packet", got, exp);
                    end
                end
                prevEn = enable;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [103:0] pkt;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        readPacket(pkt);
        checkOutput("reset_packet", pkt, makePacket(0, 0, 0));
        for (int s = 13; s < 16; s++) begin
            select = 4'(s);
            #1;
            checkOutput("select_out_of_range", {96'd0, data_out}, 104'd0);
        end
        checkOutput("reset_enable", {103'd0, enable}, 104'd1);
        checkOutput("reset_busy", {103'd0, busy}, 104'd0);
        checkOutput("reset_overrun", {103'd0, overrun}, 104'd0);

        // Full-scale sample with downstream idle: load 14 edges after the strobe
        fsm_state = 2'd2;
        expQ.push_back(makePacket(3, 4095, 0));
        applyStimulus(4095, 3);
        checkOutput("busy_after_strobe", {103'd0, busy}, 104'd1);
        repeat (13) tick();
        checkOutput("enable_before_load", {103'd0, enable}, 104'd1);
        tick();
        checkOutput("enable_at_load", {103'd0, enable}, 104'd0);
        tick();
        checkOutput("enable_held_handoff", {103'd0, enable}, 104'd0);
        fsm_state = 2'd0;
        tick();
        checkOutput("enable_release", {103'd0, enable}, 104'd1);
        checkOutput("busy_release", {103'd0, busy}, 104'd0);

        // Overrun during CONVERT drops the sample and leaves the live packet intact
        expQ.push_back(makePacket(0, 7, 1));
        applyStimulus(7, 0);
        tick();
        tick();
        applyStimulus(999, 6);
        checkOutput("overrun_pulse", {103'd0, overrun}, 104'd1);
        tick();
        checkOutput("overrun_cleared", {103'd0, overrun}, 104'd0);
        repeat (15) tick();
        readPacket(pkt);
        checkOutput("packet_held_during_convert", pkt, makePacket(3, 4095, 0));
        checkOutput("enable_wait_idle", {103'd0, enable}, 104'd1);
        fsm_state = 2'd2;
        tick();
        checkOutput("enable_load_after_wait", {103'd0, enable}, 104'd0);
        tick();
        fsm_state = 2'd0;
        tick();

        // Downstream busy writing: READY must wait and the packet must not change
        fsm_state = 2'd1;
        expQ.push_back(makePacket(5, 2048, 2));
        applyStimulus(2048, 5);
        repeat (18) tick();
        checkOutput("enable_blocked_by_write", {103'd0, enable}, 104'd1);
        readPacket(pkt);
        checkOutput("packet_held_during_write", pkt, makePacket(0, 7, 1));
        fsm_state = 2'd2;
        tick();
        checkOutput("enable_load_after_write", {103'd0, enable}, 104'd0);
        tick();
        fsm_state = 2'd0;
        tick();
        checkOutput("busy_idle_after_write", {103'd0, busy}, 104'd0);

        // Sequence counting from a fresh reset, then wrap at 0xFFFF
        reset_n = 1'b0;
        #5;
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 11; k++) begin
            fsm_state = 2'd2;
            expQ.push_back(makePacket(k % 8, 1000, k));
            applyStimulus(1000, k % 8);
            waitEnable(1'b0, 20, "seq_enable_low");
            fsm_state = 2'd0;
            waitEnable(1'b1, 5, "seq_enable_high");
        end
        force dut.seq = 16'hFFFF;
        tick();
        release dut.seq;
        fsm_state = 2'd2;
        expQ.push_back(makePacket(2, 4095, 16'hFFFF));
        applyStimulus(4095, 2);
        waitEnable(1'b0, 20, "wrap_enable_low");
        fsm_state = 2'd0;
        waitEnable(1'b1, 5, "wrap_enable_high");
        fsm_state = 2'd2;
        expQ.push_back(makePacket(7, 0, 0));
        applyStimulus(0, 7);
        waitEnable(1'b0, 20, "wrapped_enable_low");
        fsm_state = 2'd0;
        waitEnable(1'b1, 5, "wrapped_enable_high");

        // Reset in the middle of a conversion discards it entirely
        applyStimulus(1234, 4);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("abort_enable", {103'd0, enable}, 104'd1);
        checkOutput("abort_busy", {103'd0, busy}, 104'd0);
        checkOutput("abort_overrun", {103'd0, overrun}, 104'd0);
        readPacket(pkt);
        checkOutput("abort_packet", pkt, makePacket(0, 0, 0));
        #5;
        reset_n = 1'b1;
        tick();
        fsm_state = 2'd2;
        expQ.push_back(makePacket(4, 1234, 0));
        applyStimulus(1234, 4);
        waitEnable(1'b0, 20, "post_abort_enable_low");
        fsm_state = 2'd0;
        waitEnable(1'b1, 5, "post_abort_enable_high");

        repeat (3) tick();
        checkOutput("scoreboard_drained", 104'(expQ.size()), 104'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/sample_packetizer.md
Name: sample_packetizer

Overview:
Sits directly upstream of the FT232H FIFO-write FSM.
- Captures one ADC sample per strobe and converts it to decimal ASCII with a sequential binary-to-BCD converter.
- Assembles a 13-character packet and serves the character addressed by the FSM's select index on data_out.
- Handshakes with the FSM through enable (low = new packet ready) so a packet is never overwritten while it is being sent.

Parameters:
SEQ_W, 16, width of the packet sequence counter (rendered as 4 hex digits; must stay 16)
CONV_CYCLES, 12, double-dabble iterations; equals the sample width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
sample_valid  in  1  one-cycle strobe qualifying sample/channel
sample  in  12  unsigned ADC code, 0..4095
channel  in  3  source channel, 0..7
fsm_state  in  2  downstream FIFO FSM state (0 = check TXE, 1 = write, 2 = idle/wait)
select  in  4  downstream character index, 0..12
data_out  out  8  ASCII character for the current select (combinational mux of output registers)
enable  out  1  low = packet ready for downstream; high = no new packet
busy  out  1  high in any state other than IDLE
overrun  out  1  one-cycle pulse when sample_valid arrives while busy

Behaviour:
- Clock and reset: clk; reset_n asynchronous, active-low.
- Reset values:
  - state = IDLE; enable = 1; busy = 0; overrun = 0; seq = 0.
  - Output packet registers hold "C0:0000,0000\n".
  - After reset the downstream FSM sends this packet once. This is harmless and is the defined behaviour.
- Packet layout (select -> char):
  - 0 'C'; 1 '0'+channel; 2 ':'
  - 3..6 BCD thousands..units of sample
  - 7 ','
  - 8..11 seq hex digits, MSB first ('0'-'9', 'A'-'F' uppercase)
  - 12 0x0A
  - select 13..15 -> 0x00.
- Working registers (sample, channel, BCD) are separate from the output packet registers (double buffer).
- States:
  - IDLE:
    - On sample_valid, latch sample and channel, clear BCD, go to CONVERT.
  - CONVERT:
    - One shift-add-3 iteration per cycle for exactly CONV_CYCLES cycles, then go to READY.
    - Total: sample_valid at edge N -> READY at edge N+13.
  - READY:
    - Wait until fsm_state == 2.
    - On that edge: load output registers from working registers with the current seq; enable <= 0; seq <= seq+1 (wraps 0xFFFF -> 0x0000); go to HANDOFF.
    - If fsm_state != 2, output registers and enable are held unchanged.
  - HANDOFF:
    - Hold enable = 0 until fsm_state != 2.
    - On that edge: enable <= 1; go to IDLE.
- Output registers change only in the single READY -> HANDOFF edge, while downstream is idle. This guarantees no mid-packet corruption.
- sample_valid in CONVERT, READY or HANDOFF:
  - Sample is dropped.
  - overrun = 1 for the following cycle only.
  - Working registers are unaffected.
- sample_valid on the same edge the block returns to IDLE is dropped and flagged overrun. The block accepts samples only while already in IDLE.
- A reset mid-operation aborts conversion and restores all reset values. Any partial packet is discarded; seq returns to 0.
- BCD result of 4095 is 4-0-9-5. No saturation is needed because a 12-bit input is at most 4 digits.

Decomposition:
- Package oscope_pkg:
  - PKT_LEN = 13
  - ASCII constants ('C', ':', ',', LF, '0', 'A')
  - FIFO FSM state encodings FIFO_S0/S1/S2 = 0/1/2 (shared with the FIFO FSM)
  - packetizer state typedef {IDLE, CONVERT, READY, HANDOFF}
- Sub-module bin2bcd_seq:
  - Ports: start, 12-bit in, done, 16-bit BCD out.
  - Iterative double-dabble, CONV_CYCLES cycles.

Test Plan:
1. Reset, select swept 0..12 -> data_out reads "C0:0000,0000\n", 0x00 for select 13..15; enable=1, busy=0.
2. fsm_state=2 held; sample=4095, channel=3 strobed -> busy next cycle; enable=0 exactly 14 edges after strobe; packet "C3:4095,0000\n". Then fsm_state=0 -> enable=1 next edge, IDLE.
3. Second strobe sample=7, ch=0 during CONVERT -> overrun pulses 1 cycle, packet still "C3:4095,...". Next accepted sample=7 -> "C0:0007,0001\n".
4. Conversion completes while fsm_state=1 -> enable stays 1 and data_out unchanged. Once fsm_state=2 -> load and enable=0 on that edge.
5. Eleven packets sample=1000 each -> eleventh packet shows seq "000A". Force seq preset to 0xFFFF -> packet "FFFF", next packet "0000".
6. reset_n asserted at cycle 5 of CONVERT -> all outputs at reset values immediately. After release, a new sample converts normally with seq "0000".
